// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch/data request buses and the shared memory port
// Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        d_store_type;
    logic [2:0]        d_load_type;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    // Arbiter side: serves the requesters and drives the memory port.
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_store_type, d_load_type,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    // Environment side: the core requesters plus the memory.
    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_store_type, d_load_type,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and load/store
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input wire clk,
    input wire rst_n,
    mem_port_arbiter_if.master bus
);
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_FETCH = 2'd1;
    localparam logic [1:0] C_DATA  = 2'd2;
    localparam logic [1:0] C_RESP  = 2'd3;

    localparam logic C_GRANT_FETCH = 1'b0;
    localparam logic C_GRANT_DATA  = 1'b1;

    localparam logic [1:0] C_ST_SB = 2'b00;
    localparam logic [1:0] C_ST_SH = 2'b01;

    localparam logic [2:0] C_LT_LBU = 3'b000;
    localparam logic [2:0] C_LT_LHU = 3'b001;
    localparam logic [2:0] C_LT_LB  = 3'b100;
    localparam logic [2:0] C_LT_LH  = 3'b101;

    localparam logic [7:0] C_WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]        r_state, w_state_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic [7:0]        r_wait_cnt, w_wait_cnt_nxt;
    logic [1:0]        r_addr_lo, w_addr_lo_nxt;
    logic              r_we, w_we_nxt;
    logic [2:0]        r_load_type, w_load_type_nxt;

    logic              r_if_gnt, r_if_rvalid, r_if_err;
    logic [31:0]       r_if_rdata;
    logic              r_d_gnt, r_d_rvalid, r_d_err;
    logic [31:0]       r_d_rdata;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;

    logic              w_if_gnt_nxt, w_if_rvalid_nxt, w_if_err_nxt;
    logic [31:0]       w_if_rdata_nxt;
    logic              w_d_gnt_nxt, w_d_rvalid_nxt, w_d_err_nxt;
    logic [31:0]       w_d_rdata_nxt;
    logic              w_mem_req_nxt, w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [31:0]       w_mem_wdata_nxt;
    logic [3:0]        w_mem_be_nxt;

    logic              w_pick_fetch, w_pick_data;
    logic              w_if_misal, w_d_misal;
    logic [3:0]        w_d_be;
    logic [31:0]       w_d_wdata;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_load_data;
    logic              w_timeout;

    // Tie-break favours whichever side was not served last.
    assign w_pick_fetch = bus.if_req && (!bus.d_req || (r_last_grant == C_GRANT_DATA));
    assign w_pick_data  = bus.d_req && !w_pick_fetch;
    assign w_if_misal   = (bus.if_addr[1:0] != 2'b00);
    assign w_timeout    = (r_wait_cnt == C_WAIT_LAST);

    always_comb begin
        w_d_misal = 1'b0;
        if (bus.d_we) begin
            case (bus.d_store_type)
                C_ST_SB: w_d_misal = 1'b0;
                C_ST_SH: w_d_misal = bus.d_addr[0];
                default: w_d_misal = (bus.d_addr[1:0] != 2'b00);
            endcase
        end else begin
            case (bus.d_load_type)
                C_LT_LBU, C_LT_LB: w_d_misal = 1'b0;
                C_LT_LHU, C_LT_LH: w_d_misal = bus.d_addr[0];
                default:           w_d_misal = (bus.d_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        w_d_be    = 4'hF;
        w_d_wdata = '0;
        if (bus.d_we) begin
            case (bus.d_store_type)
                C_ST_SB: begin
                    w_d_be    = 4'b0001 << bus.d_addr[1:0];
                    w_d_wdata = {4{bus.d_wdata[7:0]}};
                end
                C_ST_SH: begin
                    w_d_be    = 4'b0011 << bus.d_addr[1:0];
                    w_d_wdata = {2{bus.d_wdata[15:0]}};
                end
                default: begin
                    w_d_be    = 4'hF;
                    w_d_wdata = bus.d_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (r_addr_lo)
            2'd0:    w_ld_byte = bus.mem_rdata[7:0];
            2'd1:    w_ld_byte = bus.mem_rdata[15:8];
            2'd2:    w_ld_byte = bus.mem_rdata[23:16];
            default: w_ld_byte = bus.mem_rdata[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_load_type)
            C_LT_LB:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            C_LT_LBU: w_load_data = {24'd0, w_ld_byte};
            C_LT_LH:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
            C_LT_LHU: w_load_data = {16'd0, w_ld_half};
            default:  w_load_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= C_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_pick_fetch)     w_state_nxt = w_if_misal ? C_RESP : C_FETCH;
                else if (w_pick_data) w_state_nxt = w_d_misal  ? C_RESP : C_DATA;
            end
            C_FETCH, C_DATA: begin
                if (bus.mem_ready || w_timeout) w_state_nxt = C_RESP;
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // Next values for every registered output; pulses default low so RESP clears them.
    always_comb begin
        w_if_gnt_nxt     = 1'b0;
        w_if_rvalid_nxt  = 1'b0;
        w_if_err_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_gnt_nxt      = 1'b0;
        w_d_rvalid_nxt   = 1'b0;
        w_d_err_nxt      = 1'b0;
        w_d_rdata_nxt    = r_d_rdata;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_be_nxt     = r_mem_be;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_last_grant_nxt = r_last_grant;
        w_addr_lo_nxt    = r_addr_lo;
        w_we_nxt         = r_we;
        w_load_type_nxt  = r_load_type;
        case (r_state)
            C_IDLE: begin
                if (w_pick_fetch) begin
                    w_if_gnt_nxt     = 1'b1;
                    w_last_grant_nxt = C_GRANT_FETCH;
                    w_addr_lo_nxt    = bus.if_addr[1:0];
                    w_we_nxt         = 1'b0;
                    if (w_if_misal) begin
                        w_if_err_nxt = 1'b1;
                    end else begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = {bus.if_addr[ADDR_W-1:2], 2'b00};
                        w_mem_wdata_nxt = '0;
                        w_mem_be_nxt    = 4'hF;
                        w_wait_cnt_nxt  = '0;
                    end
                end else if (w_pick_data) begin
                    w_d_gnt_nxt      = 1'b1;
                    w_last_grant_nxt = C_GRANT_DATA;
                    w_addr_lo_nxt    = bus.d_addr[1:0];
                    w_we_nxt         = bus.d_we;
                    w_load_type_nxt  = bus.d_load_type;
                    if (w_d_misal) begin
                        w_d_err_nxt = 1'b1;
                    end else begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = bus.d_we;
                        w_mem_addr_nxt  = {bus.d_addr[ADDR_W-1:2], 2'b00};
                        w_mem_wdata_nxt = w_d_wdata;
                        w_mem_be_nxt    = w_d_be;
                        w_wait_cnt_nxt  = '0;
                    end
                end
            end
            C_FETCH, C_DATA: begin
                if (bus.mem_ready) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_state == C_FETCH) begin
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = bus.mem_rdata;
                    end else begin
                        w_d_rvalid_nxt = 1'b1;
                        w_d_rdata_nxt  = r_we ? 32'd0 : w_load_data;
                    end
                end else if (w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_state == C_FETCH) w_if_err_nxt = 1'b1;
                    else                    w_d_err_nxt  = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= C_GRANT_DATA;
            r_wait_cnt   <= '0;
            r_addr_lo    <= '0;
            r_we         <= 1'b0;
            r_load_type  <= '0;
            r_if_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_gnt      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_err      <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            r_we         <= w_we_nxt;
            r_load_type  <= w_load_type_nxt;
            r_if_gnt     <= w_if_gnt_nxt;
            r_if_rvalid  <= w_if_rvalid_nxt;
            r_if_err     <= w_if_err_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_gnt      <= w_d_gnt_nxt;
            r_d_rvalid   <= w_d_rvalid_nxt;
            r_d_err      <= w_d_err_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_be     <= w_mem_be_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the load/store path.
- Arbitrates between the two requesters and sequences each access through a wait-state-tolerant handshake.
- Generates byte enables and store lane data from the control unit's store_type, and extracts and extends load data per load_type.
- Detects misaligned accesses and memory timeouts.

Parameters:
ADDR_W, 32, byte address width
MAX_WAIT, 15, cycles mem_req may wait for mem_ready before timeout (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held until if_rvalid or if_err
if_addr  in  ADDR_W  fetch address (word-aligned)
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction word
if_err  out  1  one-cycle pulse: fetch misaligned or timed out
d_req  in  1  data request; held until d_rvalid or d_err
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_store_type  in  2  00 sb, 01 sh, 10 sw
d_load_type  in  3  100 lb, 101 lh, 110 lw, 001 lhu, 000 lbu
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  32  formatted load data (0 for stores)
d_err  out  1  one-cycle pulse: misaligned or timeout
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word address; bits [1:0] forced to 0
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  memory completes access this cycle
mem_rdata  in  32  read data, valid when mem_ready

Behaviour:
- Reset: FSM in IDLE. All outputs 0. Wait counter 0. last_grant = DATA.
- FSM states: IDLE, FETCH, DATA, RESP. All outputs are registered.
- Arbitration (IDLE only):
  - Only one requester: that requester wins.
  - Both requesting: the requester not in last_grant wins (strict alternation). Post-reset, a tie goes to FETCH.
- Acceptance cycle N:
  - Pulse the winner's gnt at N+1.
  - Latch the address, type, we and wdata.
  - Update last_grant.
- Alignment is checked at acceptance:
  - Errors: sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0; fetch with if_addr[1:0]!=0.
  - On error: the err pulse occurs at N+1 together with gnt. No mem_req. The FSM goes to RESP.
- Valid access, cycle N+1:
  - mem_req=1; mem_addr={addr[ADDR_W-1:2],2'b00}; mem_we=d_we (0 for fetch).
  - The FSM enters FETCH or DATA, and the wait counter is cleared.
- Byte enables and store data:
  - sb: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - sh: be=0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - sw: be=1111, wdata passed through.
  - Loads and fetch: be=1111.
- In FETCH/DATA:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_be are held stable.
  - If mem_ready=1 in cycle M: drop mem_req at M+1 and pulse rvalid at M+1.
  - Otherwise the counter increments. If the counter reaches MAX_WAIT with mem_ready still 0: drop mem_req and pulse err on the next cycle. A late mem_ready is ignored.
- Load formatting:
  - Byte selected by addr[1:0]; half by addr[1].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
  - Undefined load_type codes behave as lw.
- RESP: one bubble cycle that clears the pulses, then back to IDLE. Maximum throughput is one access per 3 cycles plus memory wait states.
- The requester must keep req high until its rvalid/err. A req that drops after gnt is ignored; the access completes anyway.
- Simultaneous mem_ready and timeout on the same cycle: mem_ready wins.
- Reset mid-access: mem_req drops on the next edge, the FSM returns to IDLE, and no pulses are generated.
- Only one of rvalid/err is ever pulsed per accepted request. if_* and d_* pulses are never concurrent.

Test Plan:
1. Fetch, if_addr=0x100, mem_ready on the 2nd cycle of mem_req, mem_rdata=0x00A00093 -> if_gnt, mem_addr=0x100, be=1111, if_rvalid with if_rdata=0x00A00093.
2. sb, d_addr=0x203, d_wdata=0x12345678 -> mem_be=1000, mem_wdata=0x78787878, mem_we=1, addr 0x200, then d_rvalid.
3. lb at 0x202 with mem_rdata=0x1180FF22 -> d_rdata=0xFFFFFF80. Same access with lbu -> 0x00000080. lh at 0x202 -> 0x00001180.
4. lw at 0x206 -> d_gnt and d_err on the same cycle, mem_req never asserted. sh at 0x201 -> d_err.
5. if_req and d_req held continuously after reset -> grants alternate FETCH, DATA, FETCH, DATA.
6. mem_ready held 0, MAX_WAIT=4 -> mem_req high 4 cycles, then d_err pulse. Separately, rst_n=0 mid-wait -> mem_req=0 next cycle, no pulses.
